// File: rtl/sr_drive_pkg.sv
// Shared state encoding, timing defaults and counter sizing for the SR latch drive controller.
package sr_drive_pkg;

    localparam int DB_CYCLES_DEF = 4;
    localparam int PULSE_W_DEF   = 2;
    localparam int GAP_W_DEF     = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        RST_P = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Width that holds the longest of the pulse/gap terminal counts with headroom.
    function automatic int cnt_width(input int pulse_w, input int gap_w);
        int m;
        m = (pulse_w > gap_w) ? pulse_w : gap_w;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, stable-count debouncer and rising-edge strobe for one button.
module sr_debounce
    import sr_drive_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    localparam int            CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] TC = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= din;
            sync2   <= sync1;
            level_d <= level;
            // Any cycle that agrees with the current level restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == TC) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Debounced set/reset buttons driving non-overlapping active-low pulses into an SR latch.
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int PULSE_W   = PULSE_W_DEF,
    parameter int GAP_W     = GAP_W_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic SET_REQ,
    input  logic RST_REQ,
    output logic SBAR,
    output logic RBAR,
    output logic Q_EXP,
    output logic BUSY,
    output logic CONFLICT
);

    localparam int            CW       = cnt_width(PULSE_W, GAP_W);
    localparam logic [CW-1:0] PULSE_TC = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_TC   = CW'(GAP_W - 1);

    generate
        if (PULSE_W < 1 || GAP_W < 1 || DB_CYCLES < 1) begin : g_bad_param
            $error("sr_drive_ctrl: PULSE_W, GAP_W and DB_CYCLES must be >= 1");
        end
    endgenerate

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          pend_set;
    logic          pend_rst;
    logic          set_ev;
    logic          rst_ev;
    logic          want_set;
    logic          want_rst;
    logic          decide;
    logic          sbar_nxt;
    logic          rbar_nxt;
    logic          busy_nxt;
    logic          q_nxt;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
        .clk  (CLK),
        .rst  (RST),
        .din  (SET_REQ),
        .rise (set_ev)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
        .clk  (CLK),
        .rst  (RST),
        .din  (RST_REQ),
        .rise (rst_ev)
    );

    // Pending flags are always clear in IDLE, so this reduces to the raw events there.
    assign want_set = pend_set | set_ev;
    assign want_rst = pend_rst | rst_ev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_set <= 1'b0;
            pend_rst <= 1'b0;
            SBAR     <= 1'b1;
            RBAR     <= 1'b1;
            BUSY     <= 1'b0;
            Q_EXP    <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state || next_state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (decide) begin
                pend_set <= 1'b0;
                pend_rst <= 1'b0;
            end else begin
                pend_set <= pend_set | set_ev;
                pend_rst <= pend_rst | rst_ev;
            end
            SBAR  <= sbar_nxt;
            RBAR  <= rbar_nxt;
            BUSY  <= busy_nxt;
            Q_EXP <= q_nxt;
        end
    end

    always_comb begin
        next_state = state;
        decide     = 1'b0;
        case (state)
            IDLE:         decide = 1'b1;
            SET_P, RST_P: if (cnt == PULSE_TC) next_state = GAP;
            GAP:          if (cnt == GAP_TC) decide = 1'b1;
            default:      next_state = IDLE;
        endcase
        // Reset always wins; a coincident set is dropped rather than queued.
        if (decide) begin
            if (want_rst) begin
                next_state = RST_P;
            end else if (want_set) begin
                next_state = SET_P;
            end else begin
                next_state = IDLE;
            end
        end
    end

    always_comb begin
        sbar_nxt = (next_state != SET_P);
        rbar_nxt = (next_state != RST_P);
        busy_nxt = (next_state != IDLE);
        q_nxt    = Q_EXP;
        if (next_state == SET_P && state != SET_P) begin
            q_nxt = 1'b1;
        end else if (next_state == RST_P && state != RST_P) begin
            q_nxt = 1'b0;
        end
        CONFLICT = decide & want_rst & want_set;
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed checks of debounce latency, pulse shaping, reset priority and reset behaviour.
module tb_sr_drive_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic SET_REQ;
    logic RST_REQ;
    logic SBAR;
    logic RBAR;
    logic Q_EXP;
    logic BUSY;
    logic CONFLICT;

    int checks    = 0;
    int errors    = 0;
    int sbar_lows = 0;
    int rbar_lows = 0;
    int s0;
    int r0;

    sr_drive_ctrl #(.DB_CYCLES(4), .PULSE_W(2), .GAP_W(1)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SET_REQ  (SET_REQ),
        .RST_REQ  (RST_REQ),
        .SBAR     (SBAR),
        .RBAR     (RBAR),
        .Q_EXP    (Q_EXP),
        .BUSY     (BUSY),
        .CONFLICT (CONFLICT)
    );

    always #5 CLK = ~CLK;

    // Counts low cycles of each drive; sampled before the edge updates the outputs.
    always @(posedge CLK) begin
        if (SBAR === 1'b0) sbar_lows++;
        if (RBAR === 1'b0) rbar_lows++;
    end

    always @(negedge CLK) begin
        checks++;
        assert ((SBAR | RBAR) === 1'b1)
        else begin
            errors++;
            $error("FAIL sbar_rbar_excl observed SBAR=%b RBAR=%b required SBAR|RBAR=1", SBAR, RBAR);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        RST     = 1'b1;
        SET_REQ = 1'b0;
        RST_REQ = 1'b0;
        tick(3);
        check("rst_sbar", SBAR, 1'b1);
        check("rst_rbar", RBAR, 1'b1);
        check("rst_q", Q_EXP, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_conflict", CONFLICT, 1'b0);
        RST = 1'b0;
        tick(3);

        // Same-edge set and reset: reset served, set dropped.
        s0 = sbar_lows; r0 = rbar_lows;
        SET_REQ = 1'b1; RST_REQ = 1'b1;
        tick(6);
        check("cf_conflict_dec", CONFLICT, 1'b1);
        check("cf_rbar_pre", RBAR, 1'b1);
        tick(1);
        check("cf_rbar_c7", RBAR, 1'b0);
        check("cf_sbar_c7", SBAR, 1'b1);
        check("cf_conflict_c7", CONFLICT, 1'b0);
        check("cf_q_c7", Q_EXP, 1'b0);
        tick(1);
        check("cf_rbar_c8", RBAR, 1'b0);
        tick(1);
        check("cf_rbar_gap", RBAR, 1'b1);
        check("cf_busy_gap", BUSY, 1'b1);
        tick(1);
        check("cf_busy_idle", BUSY, 1'b0);
        check("cf_q_end", Q_EXP, 1'b0);
        tick(2);
        check_int("cf_sbar_lows", sbar_lows - s0, 0);
        check_int("cf_rbar_lows", rbar_lows - r0, 2);
        SET_REQ = 1'b0; RST_REQ = 1'b0;
        tick(12);

        // Clean set press held for 10 cycles.
        s0 = sbar_lows;
        SET_REQ = 1'b1;
        tick(6);
        check("set_sbar_c6", SBAR, 1'b1);
        check("set_busy_c6", BUSY, 1'b0);
        tick(1);
        check("set_sbar_c7", SBAR, 1'b0);
        check("set_q_c7", Q_EXP, 1'b1);
        check("set_busy_c7", BUSY, 1'b1);
        tick(1);
        check("set_sbar_c8", SBAR, 1'b0);
        check("set_busy_c8", BUSY, 1'b1);
        tick(1);
        check("set_sbar_c9", SBAR, 1'b1);
        check("set_busy_c9", BUSY, 1'b1);
        tick(1);
        check("set_busy_c10", BUSY, 1'b0);
        check("set_q_c10", Q_EXP, 1'b1);
        SET_REQ = 1'b0;
        tick(12);
        check_int("set_sbar_lows", sbar_lows - s0, 2);
        check("set_q_hold", Q_EXP, 1'b1);

        // Bouncing set press settles into exactly one pulse.
        s0 = sbar_lows;
        SET_REQ = 1'b1; tick(1);
        SET_REQ = 1'b0; tick(1);
        SET_REQ = 1'b1; tick(1);
        SET_REQ = 1'b0; tick(1);
        SET_REQ = 1'b1;
        tick(6);
        check("bnc_sbar_c6", SBAR, 1'b1);
        check("bnc_busy_c6", BUSY, 1'b0);
        tick(1);
        check("bnc_sbar_c7", SBAR, 1'b0);
        tick(12);
        check_int("bnc_sbar_lows", sbar_lows - s0, 2);
        check("bnc_busy_end", BUSY, 1'b0);
        SET_REQ = 1'b0;
        tick(12);

        // Reset event lands during SET_P and is served after the gap.
        SET_REQ = 1'b1;
        tick(1);
        RST_REQ = 1'b1;
        tick(6);
        check("pend_sbar_c7", SBAR, 1'b0);
        check("pend_q_c7", Q_EXP, 1'b1);
        tick(1);
        check("pend_sbar_c8", SBAR, 1'b0);
        tick(1);
        check("pend_sbar_gap", SBAR, 1'b1);
        check("pend_rbar_gap", RBAR, 1'b1);
        check("pend_busy_gap", BUSY, 1'b1);
        check("pend_conflict_gap", CONFLICT, 1'b0);
        tick(1);
        check("pend_rbar_c10", RBAR, 1'b0);
        check("pend_q_c10", Q_EXP, 1'b0);
        tick(1);
        check("pend_rbar_c11", RBAR, 1'b0);
        tick(1);
        check("pend_rbar_c12", RBAR, 1'b1);
        check("pend_busy_c12", BUSY, 1'b1);
        tick(1);
        check("pend_busy_c13", BUSY, 1'b0);
        check("pend_q_end", Q_EXP, 1'b0);
        SET_REQ = 1'b0; RST_REQ = 1'b0;
        tick(12);

        // RST in the first SET_P cycle kills the pulse outright.
        SET_REQ = 1'b1;
        tick(7);
        check("abort_sbar_c7", SBAR, 1'b0);
        check("abort_busy_c7", BUSY, 1'b1);
        RST = 1'b1; SET_REQ = 1'b0;
        tick(1);
        check("abort_sbar", SBAR, 1'b1);
        check("abort_rbar", RBAR, 1'b1);
        check("abort_busy", BUSY, 1'b0);
        check("abort_q", Q_EXP, 1'b0);
        RST = 1'b0;
        s0 = sbar_lows;
        tick(15);
        check_int("abort_no_pulse", sbar_lows - s0, 0);
        check("abort_busy_end", BUSY, 1'b0);

        // Set button held through reset release yields one event.
        RST = 1'b1; SET_REQ = 1'b1;
        tick(3);
        RST = 1'b0;
        s0 = sbar_lows;
        tick(6);
        check("hold_sbar_c6", SBAR, 1'b1);
        check("hold_q_c6", Q_EXP, 1'b0);
        tick(1);
        check("hold_sbar_c7", SBAR, 1'b0);
        check("hold_q_c7", Q_EXP, 1'b1);
        tick(12);
        check_int("hold_sbar_lows", sbar_lows - s0, 2);
        check("hold_busy_end", BUSY, 1'b0);
        SET_REQ = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high (clock port CLK, reset port RST).
REQ-002 Parameters (name, default, meaning), one per line:
- DB_CYCLES, 4: consecutive stable cycles required to accept a new input level.
- PULSE_W, 2: width of the active-low SBAR/RBAR pulse, in cycles.
- GAP_W, 1: minimum cycles with both SBAR and RBAR high between two pulses.
REQ-003 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1: clock, rising edge.
- RST, in, 1: synchronous active-high reset.
- SET_REQ, in, 1: raw asynchronous set button, active-high.
- RST_REQ, in, 1: raw asynchronous reset button, active-high.
- SBAR, out, 1: active-low set drive to the downstream SR latch.
- RBAR, out, 1: active-low reset drive to the downstream SR latch.
- Q_EXP, out, 1: expected latch Q after the last issued pulse.
- BUSY, out, 1: high whenever the FSM is not in IDLE.
- CONFLICT, out, 1: one-cycle pulse when a set request is dropped due to reset priority.

Function
REQ-004 Each raw input SHALL pass a 2-flop synchronizer, then a debouncer.
REQ-005 The debouncer output SHALL change only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count from zero.
REQ-006 A request event SHALL be a 0->1 transition of the debounced level (one-cycle strobe); 1->0 transitions SHALL generate no event.
REQ-007 FSM states SHALL be IDLE, SET_P, RST_P and GAP.
REQ-008 IDLE -> RST_P on a reset event; IDLE -> SET_P on a set event with no reset event.
REQ-009 SET_P/RST_P SHALL last exactly PULSE_W cycles, then go to GAP.
REQ-010 GAP SHALL last exactly GAP_W cycles, then go to RST_P if a reset is pending, else SET_P if a set is pending, else IDLE.
REQ-011 SBAR SHALL be 0 only in SET_P and RBAR 0 only in RST_P; SBAR=RBAR=0 SHALL never occur.
REQ-012 SBAR/RBAR/BUSY SHALL be registered outputs driven from the state register, with no combinational path from inputs.
REQ-013 Latency: with defaults, SBAR/RBAR SHALL go low on the 7th rising edge after the first edge that samples the new stable raw level (2 sync + DB_CYCLES + 1).
REQ-014 Events arriving outside IDLE SHALL set a one-deep pending flag per channel; repeat events on the same channel SHALL merge into that flag.
REQ-015 Simultaneous set and reset (same-cycle events in IDLE, or both pending at GAP exit) SHALL serve reset and drop set, pulsing CONFLICT for one cycle in the decision cycle.
REQ-016 Q_EXP SHALL become 1 on entry to SET_P and 0 on entry to RST_P, and SHALL hold otherwise.
REQ-017 Pulse and gap counters SHALL be $clog2(max(PULSE_W,GAP_W))+1 bits wide and SHALL reset to 0 on each state entry; PULSE_W and GAP_W SHALL be >= 1.

Reset
REQ-018 On RST, the block SHALL force the following on the next edge: state=IDLE, SBAR=1, RBAR=1, Q_EXP=0, BUSY=0, CONFLICT=0, pending flags=0, counters=0, synchronizer and debounced levels=0.
REQ-019 RST asserted mid-pulse SHALL terminate the pulse at the next edge with no completing gap.
REQ-020 A raw input held high through reset release SHALL produce one event, DB_CYCLES+2 cycles after release.

Structure
REQ-021 Package sr_drive_pkg SHALL hold the FSM state enum and the parameter defaults.
REQ-022 Sub-module sr_debounce (synchronizer, debouncer and rising-edge strobe) SHALL be instantiated twice, once per channel.

Verification
REQ-023 SET_REQ held high for 10 cycles -> SBAR low for cycles 7-8, Q_EXP=1 from cycle 7, BUSY high for cycles 7-9.
REQ-024 SET_REQ bouncing 1,0,1,0 at 1-cycle intervals, then held high -> exactly one SBAR pulse, 7 cycles after the final rising level.
REQ-025 SET_REQ and RST_REQ rising on the same edge -> RBAR pulse only, CONFLICT one cycle, Q_EXP stays 0, SBAR never low.
REQ-026 RST_REQ event during SET_P -> SET_P completes, GAP for 1 cycle, then RBAR low for 2 cycles and Q_EXP ends at 0.
REQ-027 RST asserted in the 1st SET_P cycle -> SBAR=1, BUSY=0 and Q_EXP=0 at the next edge, with no later pulse.
REQ-028 A continuous assertion on every cycle SHALL check that SBAR|RBAR==1 always.
